// File: rtl/fp_adder_pkg.sv
// Shared types and constants for the single-precision add sequencer.
//   state_t       : sequencer FSM states
//   fp_unpacked_t : sign, biased exponent, 24-bit mantissa with hidden bit
//   unpack()      : splits a packed float; exponent 0 flushes to a zero mantissa
package fp_adder_pkg;

    localparam int EXP_W    = 8;
    localparam int MANT_W   = 24;
    localparam int EXP_BIAS = 127;
    localparam int EXP_MAX  = 255;

    typedef enum logic [2:0] {
        IDLE,
        ALIGN,
        ADD,
        NORM,
        DONE
    } state_t;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] mant;
    } fp_unpacked_t;

    // Exponent 255 is deliberately treated as an ordinary exponent.
    function automatic fp_unpacked_t unpack(input logic [31:0] f);
        fp_unpacked_t u;
        u.sign = f[31];
        u.exp  = f[30:23];
        u.mant = (f[30:23] == '0) ? '0 : {1'b1, f[22:0]};
        return u;
    endfunction

endpackage

// File: rtl/fp_add_sequencer_if.sv
// Request/response bundle of the add sequencer.
//   master : requester/consumer side (drives operands, tag, out_ready)
//   slave  : sequencer side (drives in_ready, result, tag, out_valid, busy)
interface fp_add_sequencer_if #(
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_a;
    logic [31:0]      in_b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_result;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    modport master (
        output in_valid, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag, busy
    );

    modport slave (
        input  in_valid, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag, busy
    );
endinterface

// File: rtl/fp_mantissa_alu.sv
// Combinational signed-magnitude adder for aligned 24-bit mantissas.
//   sign_a/mant_a, sign_b/mant_b : aligned operands
//   mag   : 24-bit result magnitude
//   carry : overflow out of bit 23 (like-sign add only)
//   sign  : result sign; exact cancellation yields 0
module fp_mantissa_alu
    import fp_adder_pkg::*;
(
    input  logic              sign_a,
    input  logic [MANT_W-1:0] mant_a,
    input  logic              sign_b,
    input  logic [MANT_W-1:0] mant_b,
    output logic [MANT_W-1:0] mag,
    output logic              carry,
    output logic              sign
);
    logic [MANT_W:0] sum;

    always_comb begin
        sum   = {1'b0, mant_a} + {1'b0, mant_b};
        mag   = '0;
        carry = 1'b0;
        sign  = 1'b0;
        if (sign_a == sign_b) begin
            mag   = sum[MANT_W-1:0];
            carry = sum[MANT_W];
            sign  = sign_a;
        end else if (mant_a > mant_b) begin
            mag  = mant_a - mant_b;
            sign = sign_a;
        end else if (mant_b > mant_a) begin
            mag  = mant_b - mant_a;
            sign = sign_b;
        end
        // equal magnitudes, unlike signs: +0 from the defaults
    end
endmodule

// File: rtl/fp_add_sequencer.sv
// Multi-cycle IEEE-754 single adder: IDLE -> ALIGN -> ADD -> NORM(xL) -> DONE.
// Truncating, denormals flush to zero, no NaN/Inf input handling.
//   clk, reset_n : clock, async active-low reset
//   bus          : request/response interface (slave side)
module fp_add_sequencer
    import fp_adder_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input  logic clk,
    input  logic reset_n,
    fp_add_sequencer_if.slave bus
);
    state_t state, state_nxt;

    logic [31:0]       op_a, op_b;
    logic [TAG_W-1:0]  tag_r;
    logic [EXP_W-1:0]  exp_r;
    logic              sa_r, sb_r;
    logic [MANT_W-1:0] ma_r, mb_r;
    logic [MANT_W-1:0] mag_r;
    logic              carry_r, sign_r;
    logic [31:0]       res_r;
    logic [TAG_W-1:0]  res_tag;

    // ---------------- alignment ----------------
    fp_unpacked_t      ua, ub;
    logic              a_big;
    logic [EXP_W-1:0]  exp_diff;
    logic [MANT_W-1:0] small_sh;

    always_comb begin
        ua       = unpack(op_a);
        ub       = unpack(op_b);
        a_big    = (ua.exp >= ub.exp);
        exp_diff = a_big ? (ua.exp - ub.exp) : (ub.exp - ua.exp);
        small_sh = '0;
        if (exp_diff < EXP_W'(MANT_W))
            small_sh = (a_big ? ub.mant : ua.mant) >> exp_diff;
    end

    // ---------------- shared mantissa ALU ----------------
    logic [MANT_W-1:0] alu_mag;
    logic              alu_carry, alu_sign;

    fp_mantissa_alu u_alu (
        .sign_a (sa_r),
        .mant_a (ma_r),
        .sign_b (sb_r),
        .mant_b (mb_r),
        .mag    (alu_mag),
        .carry  (alu_carry),
        .sign   (alu_sign)
    );

    // ---------------- normalization step decision ----------------
    logic [EXP_W:0] exp_inc;
    logic           norm_done;
    logic [31:0]    norm_res;

    always_comb begin
        exp_inc   = {1'b0, exp_r} + 1'b1;
        norm_done = 1'b1;
        norm_res  = '0;
        if (!carry_r && mag_r == '0) begin
            norm_res = '0;
        end else if (carry_r) begin
            // A 255-exponent input plus carry also lands here (exp_inc = 256).
            if (exp_inc >= (EXP_W+1)'(EXP_MAX))
                norm_res = {sign_r, 8'hFF, 23'd0};
            else
                norm_res = {sign_r, exp_inc[EXP_W-1:0], mag_r[MANT_W-1:1]};
        end else if (mag_r[MANT_W-1]) begin
            norm_res = {sign_r, exp_r, mag_r[MANT_W-2:0]};
        end else if (exp_r <= EXP_W'(1)) begin
            norm_res = '0;  // would underflow into denormal range: flush
        end else begin
            norm_done = 1'b0;
        end
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_valid) state_nxt = ALIGN;
            ALIGN:   state_nxt = ADD;
            ADD:     state_nxt = NORM;
            NORM:    if (norm_done) state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_a    <= '0;
            op_b    <= '0;
            tag_r   <= '0;
            exp_r   <= '0;
            sa_r    <= 1'b0;
            sb_r    <= 1'b0;
            ma_r    <= '0;
            mb_r    <= '0;
            mag_r   <= '0;
            carry_r <= 1'b0;
            sign_r  <= 1'b0;
            res_r   <= '0;
            res_tag <= '0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    op_a  <= bus.in_a;
                    op_b  <= bus.in_b;
                    tag_r <= bus.in_tag;
                end
                ALIGN: begin
                    exp_r <= a_big ? ua.exp : ub.exp;
                    sa_r  <= ua.sign;
                    sb_r  <= ub.sign;
                    ma_r  <= a_big ? ua.mant : small_sh;
                    mb_r  <= a_big ? small_sh : ub.mant;
                end
                ADD: begin
                    mag_r   <= alu_mag;
                    carry_r <= alu_carry;
                    sign_r  <= alu_sign;
                end
                NORM: begin
                    if (norm_done) begin
                        res_r   <= norm_res;
                        res_tag <= tag_r;
                    end else begin
                        mag_r <= mag_r << 1;
                        exp_r <= exp_r - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready   = (state == IDLE);
    assign bus.busy       = (state != IDLE);
    assign bus.out_valid  = (state == DONE);
    assign bus.out_result = res_r;
    assign bus.out_tag    = res_tag;

endmodule

// File: tb/tb_fp_add_sequencer.sv
// Self-checking bench: directed cases plus randomized operands against a
// behavioural integer model of truncating float addition.
module tb_fp_add_sequencer;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    fp_add_sequencer_if #(.TAG_W(4)) ifc ();

    fp_add_sequencer #(.TAG_W(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (ifc.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        if (obs !== want) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, want);
        end
    endtask

    // Reference: exact integer sum of aligned mantissas, then normalize.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output int l);
        int ea, eb, e, d;
        longint ma, mb, va, vb, s, mag;
        logic sg;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        ma = (ea == 0) ? 0 : longint'({1'b1, a[22:0]});
        mb = (eb == 0) ? 0 : longint'({1'b1, b[22:0]});
        if (ea >= eb) begin
            e = ea; d = ea - eb;
            mb = (d >= 24) ? 0 : (mb >> d);
        end else begin
            e = eb; d = eb - ea;
            ma = (d >= 24) ? 0 : (ma >> d);
        end
        va = a[31] ? -ma : ma;
        vb = b[31] ? -mb : mb;
        s = va + vb;
        sg = (s < 0);
        mag = sg ? -s : s;
        l = 0;
        r = 32'd0;
        if (mag == 0) begin
            r = 32'd0;
        end else if (mag >= 64'd16777216) begin
            mag = mag >> 1;
            e = e + 1;
            if (e >= 255) r = {sg, 8'hFF, 23'd0};
            else          r = {sg, e[7:0], mag[22:0]};
        end else begin
            logic flushed;
            flushed = 1'b0;
            while (mag < 64'd8388608) begin
                if (e <= 1) begin flushed = 1'b1; break; end
                mag = mag << 1;
                e = e - 1;
                l++;
            end
            r = flushed ? 32'd0 : {sg, e[7:0], mag[22:0]};
        end
    endfunction

    // One full transaction; called and returning on a negedge.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] tg,
                          input int hold, input logic [31:0] want, input int want_lat);
        int cyc;
        cyc = 0;
        while (!ifc.in_ready && cyc < 50) begin @(negedge clk); cyc++; end
        chk("in_ready_idle", 32'(ifc.in_ready), 32'd1);
        ifc.in_a = a; ifc.in_b = b; ifc.in_tag = tg; ifc.in_valid = 1'b1;
        ifc.out_ready = (hold == 0);
        @(posedge clk);
        @(negedge clk);
        ifc.in_valid = 1'b0;
        ifc.in_a = $urandom; ifc.in_b = $urandom; ifc.in_tag = 4'($urandom);
        chk("busy_after_accept", 32'(ifc.busy), 32'd1);
        cyc = 0;
        while (!ifc.out_valid && cyc < 40) begin @(negedge clk); cyc++; end
        chk("latency", 32'(cyc), 32'(want_lat));
        chk("result", ifc.out_result, want);
        chk("tag", 32'(ifc.out_tag), 32'(tg));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", 32'(ifc.out_valid), 32'd1);
            chk("hold_result", ifc.out_result, want);
            chk("hold_tag", 32'(ifc.out_tag), 32'(tg));
            chk("hold_in_ready", 32'(ifc.in_ready), 32'd0);
            chk("hold_busy", 32'(ifc.busy), 32'd1);
        end
        ifc.out_ready = 1'b1;
        @(negedge clk);
        chk("valid_dropped", 32'(ifc.out_valid), 32'd0);
        chk("in_ready_back", 32'(ifc.in_ready), 32'd1);
        ifc.out_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] a, b, r;
        int l;
        ifc.in_valid = 1'b0; ifc.in_a = '0; ifc.in_b = '0; ifc.in_tag = '0;
        ifc.out_ready = 1'b0;
        #1;
        chk("rst_in_ready", 32'(ifc.in_ready), 32'd1);
        chk("rst_busy", 32'(ifc.busy), 32'd0);
        chk("rst_out_valid", 32'(ifc.out_valid), 32'd0);
        chk("rst_out_result", ifc.out_result, 32'd0);
        chk("rst_out_tag", 32'(ifc.out_tag), 32'd0);
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        run_op(32'h3F800000, 32'h40000000, 4'h5, 0, 32'h40400000, 3);
        run_op(32'h3F800000, 32'h3F800000, 4'h6, 0, 32'h40000000, 3);
        run_op(32'h3FC00000, 32'hBF800000, 4'h7, 0, 32'h3F000000, 4);
        run_op(32'h3F800000, 32'hBF800000, 4'h8, 0, 32'h00000000, 3);
        run_op(32'h7F7FFFFF, 32'h7F7FFFFF, 4'h9, 0, 32'h7F800000, 3);
        run_op(32'h4B800000, 32'h3F800000, 4'hA, 0, 32'h4B800000, 3);
        run_op(32'h3F800000, 32'hBF7FFFFF, 4'hB, 0, 32'h34000000, 26);
        run_op(32'h00800001, 32'h80800000, 4'hC, 0, 32'h00000000, 3);
        run_op(32'h3F800000, 32'h40000000, 4'hD, 5, 32'h40400000, 3);

        // reset during NORM (long-shift operand pair)
        ifc.in_a = 32'h3F800000; ifc.in_b = 32'hBF7FFFFF; ifc.in_tag = 4'h3;
        ifc.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ifc.in_valid = 1'b0;
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(ifc.out_valid), 32'd0);
        chk("midrst_in_ready", 32'(ifc.in_ready), 32'd1);
        chk("midrst_busy", 32'(ifc.busy), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        run_op(32'h3FC00000, 32'hBF800000, 4'h4, 0, 32'h3F000000, 4);

        for (int n = 0; n < 60; n++) begin
            a = $urandom;
            case ($urandom_range(0, 2))
                0: b = $urandom;
                1: b = {~a[31], a[30:23], 23'($urandom)};
                default: b = {1'($urandom), 8'(a[30:23] + 8'($urandom_range(0, 4)) - 8'd2),
                              23'($urandom)};
            endcase
            model(a, b, r, l);
            run_op(a, b, 4'($urandom), int'($urandom_range(0, 3)), r, 3 + l);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fp_add_sequencer.md
# fp_add_sequencer

Multi-cycle IEEE-754 single-precision adder controller for the LDPC belief-propagation datapath. Accepts one operand pair per valid/ready handshake and sequences align, mantissa add and iterative normalization over several cycles. A single shared combinational mantissa ALU is reused for the add step. Returns a packed 32-bit result plus a pass-through tag on a valid/ready output port. It sits between the message-update schedulers and the node-update logic.

## Interface
- TAG_W, 4: width of the opaque request tag carried with each operation.
- clk  in  1  clock; all state changes occur on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand pair and tag are valid.
- in_ready  out  1  block can accept a request; high only in IDLE.
- in_a, in_b  in  32  IEEE-754 single operands.
- in_tag  in  TAG_W  request tag.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  consumer accepts the result.
- out_result  out  32  IEEE-754 single sum.
- out_tag  out  TAG_W  tag of the request that produced out_result.
- busy  out  1  high in any state other than IDLE.

## Operation
- The FSM has five states:
  - IDLE: in_ready=1. On in_valid, register the operands and tag, then go to ALIGN.
  - ALIGN: unpack the operands. Exponent 0 means zero (denormals flush to zero). Restore the hidden bit to form 24-bit mantissas. Exponent 255 inputs are treated as ordinary numbers; there is no NaN/Inf handling on input. Select the larger exponent and right-shift the smaller mantissa by the exponent difference. A difference of 24 or more gives a zero mantissa. Truncate; there are no guard bits. Go to ADD.
  - ADD: drive fp_mantissa_alu and register its 24-bit magnitude, carry and sign. Go to NORM.
  - NORM: act as follows each cycle.
    - Magnitude 0 and no carry: the result is +0 (0x00000000). Go to DONE.
    - Carry set: shift right by 1 (the carry becomes bit 23) and increment the exponent. If the new exponent is 255, the result is ±Inf (mantissa 0). Go to DONE.
    - Bit 23 set: go to DONE.
    - Otherwise: shift left by 1, decrement the exponent and stay in NORM. If the exponent is already 1 before the shift, the result flushes to +0. Go to DONE.
  - DONE: out_valid=1 with the result and tag registered. When out_ready is high, go to IDLE.
- Sign rules:
  - Like signs keep that sign.
  - Unlike signs take the sign of the larger magnitude.
  - An exact cancellation gives sign 0.
- Rounding is truncation only.
- out_result, out_tag and out_valid change only on entry to or exit from DONE. While out_valid=1 they are stable regardless of out_ready.

## Timing
- Reset values: state IDLE, in_ready=1, busy=0, out_valid=0, out_result=0, out_tag=0.
- Reset asserted mid-operation aborts the operation immediately with no output. The first post-reset handshake is accepted normally.
- Let L be the number of left-normalization shifts.
  - Handshake accepted at edge 0 → out_valid rises after edge 3+L.
  - L=0 for carry, already-normalized and zero results.
  - Maximum L is 23.
- out_ready already high when out_valid rises: the output handshake occurs at the next edge and in_ready is high in the following cycle. There is no IDLE bypass.
- Back-to-back throughput is one operation per 5+L cycles.
- in_valid while busy is ignored. The requester must hold it until in_ready.

## Structure
- Package fp_adder_pkg holds:
  - the state enum (IDLE, ALIGN, ADD, NORM, DONE);
  - the constants EXP_W=8, MANT_W=24, EXP_BIAS=127, EXP_MAX=255;
  - the unpacked-operand struct (sign, exponent, 24-bit mantissa).
- Sub-module fp_mantissa_alu is purely combinational. It takes two signed-magnitude 24-bit mantissas and returns a 24-bit magnitude, a carry and a sign per the sign rules above.
- fp_add_sequencer holds the FSM, the alignment shifter, the normalization registers and the output registers.

## Test plan
- 0x3F800000 + 0x40000000 (1.0+2.0) with out_ready=1 → 0x40400000, out_valid 3 cycles after accept, tag echoed.
- 0x3F800000 + 0x3F800000 → 0x40000000 via the carry path, latency 3.
- 0x3FC00000 + 0xBF800000 (1.5−1.0) → 0x3F000000, latency 4 (L=1). 0x3F800000 + 0xBF800000 → 0x00000000.
- 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000. 0x4B800000 + 0x3F800000 (exponent difference 24) → 0x4B800000.
- Hold out_ready low for 5 cycles in DONE → out_result and out_tag stable, in_ready=0 and busy=1 throughout. Asserting out_ready → IDLE one edge later.
- Assert reset_n low while in NORM → out_valid=0 and in_ready=1 immediately. A new request after release completes correctly.
